// File: rtl/cronometru_pkg.sv
// Shared definitions for the stopwatch: FSM states, BCD digit width and
// the digit limits used by the cascaded seconds/minutes counters.
package cronometru_pkg;

    typedef enum logic [1:0] {
        OPRIT  = 2'd0,  // stopped, value cleared to 00:00
        NUMARA = 2'd1,  // counting
        PAUZA  = 2'd2   // stopped, value held
    } stare_t;

    localparam int BCD_W        = 4;
    localparam int SEC_ZECI_MAX = 5;
    localparam int UNITATI_MAX  = 9;

endpackage

// File: rtl/cronometru_param_cifra_bcd.sv
// cifra_bcd: one BCD digit counting 0..MAX. Synchronous clear wins over
// enable; co_o flags that this enabled step wraps MAX back to 0.
module cifra_bcd
    import cronometru_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic             clk,
    input  logic             reseteaza_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [BCD_W-1:0] val_o,
    output logic             co_o
);

    localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MAX);

    logic [BCD_W-1:0] val_q, val_d;

    // Next digit value: clear, wrap at MAX, or step by one.
    always_comb begin
        // NOTE: val_d is assigned a default first so no branch leaves it unassigned (avoids an inferred latch).
        val_d = val_q;
        if (clr_i) begin
            val_d = '0;
        end else if (en_i) begin
            val_d = (val_q == MAX_V) ? '0 : val_q + BCD_W'(1);
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge reseteaza_n) begin
        if (!reseteaza_n) begin
            val_q <= '0;
        end else begin
            // NOTE: non-blocking so every digit in the chain samples the pre-edge values of its neighbours.
            val_q <= val_d;
        end
    end

    assign val_o = val_q;
    assign co_o  = en_i && (val_q == MAX_V);

endmodule

// File: rtl/cronometru_param.sv
// cronometru_param: MM:SS stopwatch with a one-second prescaler, cascaded
// BCD digit counters and an OPRIT/NUMARA/PAUZA control FSM.
// Optional lap (freeze-display) feature enabled by defining CRONO_TURA_EN.
module cronometru_param
    import cronometru_pkg::*;
#(
    parameter int DIV_TICK = 100000000,
    parameter int MIN_MAX  = 59
) (
    input  logic             clk,
    input  logic             reseteaza_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sterge,
    input  logic             tura,
    output logic [BCD_W-1:0] BCD0,
    output logic [BCD_W-1:0] BCD1,
    output logic [BCD_W-1:0] BCD2,
    output logic [BCD_W-1:0] BCD3,
    output logic             ruleaza,
    output logic             depasire,
    output logic             tura_activ
);

    localparam int                 PRE_W    = $clog2(DIV_TICK);
    localparam logic [PRE_W-1:0]   PRE_MAX  = PRE_W'(DIV_TICK - 1);
    localparam logic [BCD_W-1:0]   MIN_ZECI = BCD_W'(MIN_MAX / 10);
    localparam logic [BCD_W-1:0]   MIN_UNIT = BCD_W'(MIN_MAX % 10);

    stare_t           stare_q, stare_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             dep_q, dep_d;
    logic             tick, wrap, clr_cifre;
    logic [BCD_W-1:0] c0, c1, c2, c3;
    logic             co0, co1, co2, co3;
    logic [4*BCD_W-1:0] live;

    assign tick = (stare_q == NUMARA) && (pre_q == PRE_MAX);

    // Control FSM next state: stop beats start, sterge beats start outside NUMARA.
    always_comb begin
        stare_d = stare_q;
        case (stare_q)
            OPRIT:   if (start && !stop && !sterge) stare_d = NUMARA;
            NUMARA:  if (stop) stare_d = PAUZA;
            PAUZA: begin
                if (sterge)             stare_d = OPRIT;
                else if (start && !stop) stare_d = NUMARA;
            end
            default: stare_d = OPRIT;
        endcase
    end

    // Prescaler next value: runs only while counting, cleared by sterge.
    always_comb begin
        pre_d = pre_q;
        if (sterge) begin
            pre_d = '0;
        end else if (stare_q == NUMARA) begin
            pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
        end
    end

    // Wrap from MIN_MAX:59 clears all digits the same way sterge does.
    assign wrap      = co1 && (c3 == MIN_ZECI) && (c2 == MIN_UNIT);
    assign clr_cifre = sterge || wrap;
    assign dep_d     = wrap && !sterge;

    // State, prescaler and wrap-pulse registers.
    always_ff @(posedge clk or negedge reseteaza_n) begin
        if (!reseteaza_n) begin
            stare_q <= OPRIT;
            pre_q   <= '0;
            dep_q   <= 1'b0;
        end else begin
            stare_q <= stare_d;
            pre_q   <= pre_d;
            dep_q   <= dep_d;
        end
    end

    cifra_bcd #(.MAX(UNITATI_MAX)) u_sec_unit (
        .clk(clk), .reseteaza_n(reseteaza_n), .en_i(tick), .clr_i(clr_cifre),
        .val_o(c0), .co_o(co0)
    );
    cifra_bcd #(.MAX(SEC_ZECI_MAX)) u_sec_zeci (
        .clk(clk), .reseteaza_n(reseteaza_n), .en_i(co0), .clr_i(clr_cifre),
        .val_o(c1), .co_o(co1)
    );
    cifra_bcd #(.MAX(UNITATI_MAX)) u_min_unit (
        .clk(clk), .reseteaza_n(reseteaza_n), .en_i(co1), .clr_i(clr_cifre),
        .val_o(c2), .co_o(co2)
    );
    cifra_bcd #(.MAX(UNITATI_MAX)) u_min_zeci (
        .clk(clk), .reseteaza_n(reseteaza_n), .en_i(co2), .clr_i(clr_cifre),
        .val_o(c3), .co_o(co3)
    );

    assign live     = {c3, c2, c1, c0};
    assign ruleaza  = (stare_q == NUMARA);
    assign depasire = dep_q;

`ifdef CRONO_TURA_EN
    logic [4*BCD_W-1:0] tura_q, tura_d;
    logic               activ_q, activ_d;
    logic               unused_co3;

    assign unused_co3 = co3;

    // Lap control: first tura freezes the live value, second releases it.
    always_comb begin
        tura_d  = tura_q;
        activ_d = activ_q;
        if (sterge) begin
            activ_d = 1'b0;
        end else if (tura) begin
            if (activ_q) begin
                activ_d = 1'b0;
            end else if (stare_q != OPRIT) begin
                activ_d = 1'b1;
                tura_d  = live;
            end
        end
    end

    // Lap register and display-freeze flag.
    always_ff @(posedge clk or negedge reseteaza_n) begin
        if (!reseteaza_n) begin
            tura_q  <= '0;
            activ_q <= 1'b0;
        end else begin
            tura_q  <= tura_d;
            activ_q <= activ_d;
        end
    end

    assign {BCD3, BCD2, BCD1, BCD0} = activ_q ? tura_q : live;
    assign tura_activ               = activ_q;
`else
    logic unused_tura;

    assign unused_tura              = tura ^ co3;
    assign {BCD3, BCD2, BCD1, BCD0} = live;
    assign tura_activ               = 1'b0;
`endif

endmodule

// File: tb/tb_cronometru_param.sv
// Directed bench for cronometru_param (DIV_TICK=4, MIN_MAX=1): expected
// display/flag values are queued when a step is driven and compared when
// the step's result is due.
module tb_cronometru_param;

    localparam int DIV = 4;
    localparam int MM  = 1;

    logic       clk;
    logic       reseteaza_n;
    logic       start, stop, sterge, tura;
    logic [3:0] BCD0, BCD1, BCD2, BCD3;
    logic       ruleaza, depasire, tura_activ;

    int checks;
    int errors;

    typedef struct {
        string       tag;
        logic [18:0] v;
    } exp_t;

    exp_t sb[$];

    cronometru_param #(.DIV_TICK(DIV), .MIN_MAX(MM)) dut (
        .clk(clk), .reseteaza_n(reseteaza_n),
        .start(start), .stop(stop), .sterge(sterge), .tura(tura),
        .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
        .ruleaza(ruleaza), .depasire(depasire), .tura_activ(tura_activ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [18:0] enc(int mm, int ss, logic run, logic dep, logic lap);
        logic [3:0] a, b, c, d;
        a = 4'(mm / 10);
        b = 4'(mm % 10);
        c = 4'(ss / 10);
        d = 4'(ss % 10);
        return {a, b, c, d, run, dep, lap};
    endfunction

    function automatic logic [18:0] obs();
        return {BCD3, BCD2, BCD1, BCD0, ruleaza, depasire, tura_activ};
    endfunction

    task automatic expect_val(string tag, int mm, int ss, logic run, logic dep, logic lap);
        exp_t e;
        e.tag = tag;
        e.v   = enc(mm, ss, run, dep, lap);
        sb.push_back(e);
    endtask

    task automatic check_next();
        exp_t        e;
        logic [18:0] o;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%h required=none", obs());
            return;
        end
        e = sb.pop_front();
        o = obs();
        assert (o === e.v) else begin
            errors++;
            $error("FAIL %s observed={%h%h:%h%h run=%b dep=%b lap=%b} required={%h%h:%h%h run=%b dep=%b lap=%b}",
                   e.tag, o[18:15], o[14:11], o[10:7], o[6:3], o[2], o[1], o[0],
                   e.v[18:15], e.v[14:11], e.v[10:7], e.v[6:3], e.v[2], e.v[1], e.v[0]);
        end
    endtask

    task automatic check_int(string tag, int o, int e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d required=%0d", tag, o, e);
        end
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle request on the chosen inputs, driven at a falling edge.
    task automatic pulse(logic s, logic p, logic c, logic t);
        start  = s;
        stop   = p;
        sterge = c;
        tura   = t;
        @(negedge clk);
        start  = 1'b0;
        stop   = 1'b0;
        sterge = 1'b0;
        tura   = 1'b0;
    endtask

    initial begin
        int dep_cnt;
        checks      = 0;
        errors      = 0;
        dep_cnt     = 0;
        reseteaza_n = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        sterge      = 1'b0;
        tura        = 1'b0;

        // Reset state and idle after release.
        cycles(3);
        expect_val("reset", 0, 0, 0, 0, 0);
        check_next();
        reseteaza_n = 1'b1;
        cycles(2);
        expect_val("idle_after_reset", 0, 0, 0, 0, 0);
        check_next();

        // Start and count: 40 cycles are 10 ticks.
        pulse(1, 0, 0, 0);
        expect_val("run_39", 0, 9, 1, 0, 0);
        cycles(39);
        check_next();
        expect_val("run_40", 0, 10, 1, 0, 0);
        cycles(1);
        check_next();

        // Pause holds the value, resume ticks 4 cycles after start.
        pulse(0, 1, 0, 0);
        expect_val("pause_hold", 0, 10, 0, 0, 0);
        cycles(20);
        check_next();
        pulse(1, 0, 0, 0);
        expect_val("resume_pre_tick", 0, 10, 1, 0, 0);
        cycles(2);
        check_next();
        expect_val("resume_tick", 0, 11, 1, 0, 0);
        cycles(1);
        check_next();

        // start+stop together: NUMARA->PAUZA, PAUZA stays PAUZA.
        pulse(1, 1, 0, 0);
        expect_val("startstop_numara", 0, 11, 0, 0, 0);
        check_next();
        pulse(1, 1, 0, 0);
        expect_val("startstop_pauza", 0, 11, 0, 0, 0);
        check_next();
        pulse(1, 0, 0, 0);
        expect_val("restart", 0, 11, 1, 0, 0);
        check_next();

        // sterge while counting clears but keeps counting.
        pulse(0, 0, 1, 0);
        expect_val("sterge_numara", 0, 0, 1, 0, 0);
        check_next();
        expect_val("pre_sterge_tick", 0, 9, 1, 0, 0);
        cycles(39);
        check_next();
        pulse(0, 0, 1, 0);
        expect_val("sterge_beats_tick", 0, 0, 1, 0, 0);
        check_next();

        // Wrap 01:59 -> 00:00 with a single depasire pulse.
        for (int i = 0; i < 476; i++) begin
            @(negedge clk);
            if (depasire) dep_cnt++;
        end
        expect_val("at_max", 1, 59, 1, 0, 0);
        check_next();
        check_int("no_early_depasire", dep_cnt, 0);
        cycles(3);
        expect_val("wrap", 0, 0, 1, 1, 0);
        cycles(1);
        check_next();
        expect_val("wrap_pulse_end", 0, 0, 1, 0, 0);
        cycles(1);
        check_next();

`ifdef CRONO_TURA_EN
        // Lap freeze and release.
        pulse(0, 0, 1, 0);
        expect_val("lap_prep_clear", 0, 0, 1, 0, 0);
        check_next();
        cycles(12);
        expect_val("pre_lap", 0, 3, 1, 0, 0);
        check_next();
        pulse(0, 0, 0, 1);
        expect_val("lap_capture", 0, 3, 1, 0, 1);
        check_next();
        cycles(31);
        expect_val("lap_hold", 0, 3, 1, 0, 1);
        check_next();
        pulse(0, 0, 0, 1);
        expect_val("lap_release", 0, 11, 1, 0, 0);
        check_next();
        pulse(0, 0, 0, 1);
        expect_val("lap_capture2", 0, 11, 1, 0, 1);
        check_next();
        pulse(0, 0, 1, 0);
        expect_val("sterge_clears_lap", 0, 0, 1, 0, 0);
        check_next();
`else
        // Without the lap feature tura has no effect.
        pulse(0, 0, 0, 1);
        expect_val("tura_ignored", 0, 0, 1, 0, 0);
        check_next();
        pulse(0, 0, 1, 0);
        expect_val("clear_before_42", 0, 0, 1, 0, 0);
        check_next();
`endif

        // Asynchronous reset mid-tick at 00:42.
        cycles(170);
        expect_val("pre_reset_42", 0, 42, 1, 0, 0);
        check_next();
        #1;
        reseteaza_n = 1'b0;
        #1;
        expect_val("async_reset", 0, 0, 0, 0, 0);
        check_next();
        @(negedge clk);
        reseteaza_n = 1'b1;
        cycles(8);
        expect_val("oprit_after_reset", 0, 0, 0, 0, 0);
        check_next();

        // sterge+start in PAUZA goes to OPRIT; sterge+start in OPRIT stays.
        pulse(1, 0, 0, 0);
        expect_val("run_again", 0, 1, 1, 0, 0);
        cycles(4);
        check_next();
        pulse(0, 1, 0, 0);
        expect_val("stop_again", 0, 1, 0, 0, 0);
        check_next();
        pulse(1, 0, 1, 0);
        expect_val("sterge_start_pauza", 0, 0, 0, 0, 0);
        check_next();
        cycles(5);
        expect_val("stays_oprit", 0, 0, 0, 0, 0);
        check_next();
        pulse(1, 0, 1, 0);
        expect_val("sterge_start_oprit", 0, 0, 0, 0, 0);
        check_next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cronometru_param.md
CRONOMETRU_PARAM -- requirements
Module: cronometru_param

Interface
REQ-001 Parameter DIV_TICK, default 100000000: clk cycles per one-second tick; legal range >= 2.
REQ-002 Parameter MIN_MAX, default 59: highest minute value before wrap; legal range 1..99.
REQ-003 Port clk  input  1  single clock; all state on its rising edge.
REQ-004 Port reseteaza_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  synchronous one-cycle request to begin or resume counting.
REQ-006 Port stop  input  1  synchronous one-cycle request to pause counting.
REQ-007 Port sterge  input  1  synchronous clear of time value and prescaler.
REQ-008 Port tura  input  1  lap toggle request; used only when CRONO_TURA_EN is defined.
REQ-009 Port BCD0  output  4  seconds units, 0..9.
REQ-010 Port BCD1  output  4  seconds tens, 0..5.
REQ-011 Port BCD2  output  4  minutes units, 0..9.
REQ-012 Port BCD3  output  4  minutes tens, 0..MIN_MAX/10.
REQ-013 Port ruleaza  output  1  high while in state NUMARA.
REQ-014 Port depasire  output  1  one-cycle pulse on wrap from MIN_MAX:59 to 00:00.
REQ-015 Port tura_activ  output  1  high while BCD outputs show a frozen lap value.

Function
REQ-016 The FSM SHALL have states OPRIT (stopped at 00:00), NUMARA (counting), PAUZA (stopped, value held).
REQ-017 Transitions: OPRIT/PAUZA --start--> NUMARA; NUMARA --stop--> PAUZA; PAUZA --sterge--> OPRIT; NUMARA --sterge--> NUMARA with value cleared.
REQ-018 start and stop asserted in the same cycle: stop wins; state in NUMARA becomes PAUZA, state in OPRIT/PAUZA is unchanged.
REQ-019 The prescaler SHALL count 0..DIV_TICK-1 only in NUMARA, hold otherwise, and generate an internal tick in the cycle it equals DIV_TICK-1, then return to 0.
REQ-020 Time digits SHALL be held directly as cascaded BCD registers, not as binary with conversion; each digit updates on the clock edge ending the tick cycle (latency 1 cycle from tick to outputs).
REQ-021 Carry chain: BCD0 9->0 carries into BCD1; BCD1 5->0 carries into minutes; minutes increment as a two-digit BCD value.
REQ-022 At MIN_MAX:59 a tick SHALL produce 00:00 and assert depasire for exactly that one cycle; counting continues.
REQ-023 sterge SHALL zero all four digits and the prescaler in the next cycle, taking priority over a coincident tick and over start.
REQ-024 sterge together with start in OPRIT/PAUZA: sterge applied, state goes to OPRIT; start ignored that cycle.
REQ-025 Outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-026 reseteaza_n low SHALL immediately force: state OPRIT, prescaler 0, BCD0..BCD3 = 0, ruleaza = 0, depasire = 0, tura_activ = 0, lap register 0.
REQ-027 Reset deassertion mid-count resumes from OPRIT; no value is retained.

Configuration
REQ-028 Macro CRONO_TURA_EN defined: tura pulse in NUMARA or PAUZA while tura_activ = 0 captures the current value into a lap register and sets tura_activ; BCD outputs show the lap value while internal counting continues; the next tura pulse clears tura_activ and outputs show live value next cycle; sterge also clears tura_activ.
REQ-029 Macro CRONO_TURA_EN undefined: tura is ignored, no lap register exists, tura_activ is tied 0, BCD outputs always show live value.

Structure
REQ-030 Package cronometru_pkg SHALL hold the FSM state enum (OPRIT, NUMARA, PAUZA), BCD digit width constant (4), and seconds-tens limit constant (5).
REQ-031 One sub-module cifra_bcd SHALL implement a single BCD digit counter with parameterised maximum, enable, sync clear, and carry-out; cronometru_param instantiates it four times.

Verification
REQ-032 DIV_TICK=4: reset, start, run 40 cycles -> ruleaza = 1, BCD0 = 0 after 40 cycles... then BCD3..BCD0 = 0,0,1,0 (10 ticks).
REQ-033 DIV_TICK=4, MIN_MAX=1: run 120 ticks from 00:00 -> one depasire pulse at transition 01:59 -> 00:00.
REQ-034 Running at 00:07, pulse stop, wait 20 cycles, pulse start -> value stays 00:07 in PAUZA, then resumes to 00:08 after 4 cycles.
REQ-035 start and stop same cycle in NUMARA -> PAUZA; sterge coincident with tick at 00:09 -> 00:00, not 00:10.
REQ-036 CRONO_TURA_EN defined: tura at 00:03, run 8 ticks -> outputs hold 00:03, tura_activ = 1; second tura -> outputs 00:11.
REQ-037 Assert reseteaza_n low asynchronously mid-tick at 00:42 -> all outputs 0 before next clk edge, state OPRIT.
